shiftadd_operand_feeder: RTL
============================

Name: shiftadd_operand_feeder

Overview:
- Producer-side front end for the combinational shift-add folding reducer. It accepts operand pair (a, b) and modulus m over a valid/ready handshake.
- Validates ranges, derives the modulus bit-length m_bl by a sequential MSB scan, and forms the full product x = a*b with an iterative shift-add multiplier.
- Presents {x, m, m_bl} on a registered valid/ready output. That output drives x_i / m_i / m_bl_i of the reducer directly.

Parameters:
- DATA_LENGTH, 64, width of product x, modulus and bit-length outputs (matches reducer data width).
- OPERAND_WIDTH, 32, width of a, b, m inputs; must equal DATA_LENGTH/2 so a*b never overflows.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  feeder can accept (high only in IDLE).
- a_i  input  OPERAND_WIDTH  multiplicand, required a < m.
- b_i  input  OPERAND_WIDTH  multiplier, required b < m.
- m_i  input  OPERAND_WIDTH  modulus, required m >= 2.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts.
- x_o  output  DATA_LENGTH  product a*b (zero on error).
- m_o  output  DATA_LENGTH  zero-extended modulus.
- m_bl_o  output  DATA_LENGTH  bit-length of m (index of MSB + 1), zero on error.
- err_o  output  1  qualifies out_valid_o; range check failed.

Behaviour:
- Reset (async, any state) clears the following: state=IDLE, in_ready_o=1, out_valid_o=0, x_o=m_o=m_bl_o=0, err_o=0, all internal accumulators and counters 0. An in-flight request is discarded with no output.
- FSM states: IDLE, CHECK, SCAN, MUL, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o, register a, b, m and go to CHECK. in_ready_o is 0 in every other state; no input skid.
- CHECK (1 cycle): error if m<2, a>=m or b>=m. On error: x_o=0, m_o=m, m_bl_o=0, err_o=1, go to DONE. Otherwise load scan index=OPERAND_WIDTH-1 and go to SCAN.
- SCAN: tests one bit m[idx] per cycle, starting at bit 31 and moving down. When the bit is 1: m_bl=idx+1, load multiplier counter=m_bl, acc=0, shifted multiplicand=zext(a), go to MUL. Otherwise idx-=1. SCAN takes OPERAND_WIDTH+1-m_bl cycles. It always terminates because m>=2 guarantees a set bit.
- MUL: runs exactly m_bl cycles, LSB-first over b. If b[k]=1 then acc += mcand. Then mcand <<= 1 and k+=1. All arithmetic is unsigned DATA_LENGTH-bit with no truncation possible, since a,b < 2^OPERAND_WIDTH. Because b < m, bits at and above m_bl are zero, so m_bl iterations are exact. After the last iteration: x_o=acc, m_o=m, m_bl_o=m_bl, err_o=0, go to DONE.
- Latency, measured from the accepting edge:
  - Valid request: out_valid_o rises after exactly OPERAND_WIDTH+2 = 34 edges, independent of m.
  - Error: out_valid_o rises after 2 edges.
- DONE: out_valid_o=1. All outputs are held stable while out_ready_i=0, with unlimited backpressure. On out_valid_o & out_ready_i, go to IDLE, drop out_valid_o, and raise in_ready_o on the same edge.
- A new request is accepted no earlier than the edge after the output handshake. There is no back-to-back overlap, and at most one request is in flight.
- in_valid_i outside IDLE is ignored. Input values are sampled only at acceptance; later changes have no effect.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.
- Worked example: a=3, b=5, m=7.
  - CHECK passes.
  - SCAN finds bit 2 → m_bl=3, 30 SCAN cycles.
  - MUL, 3 cycles: acc 3 → 3 → 15.
  - Result: x_o=15, m_bl_o=3, valid on edge 34.

Test Plan:
- Mersenne: m=127, a=100, b=50 → edge 34: out_valid_o=1, x_o=5000, m_o=127, m_bl_o=7, err_o=0.
- Fermat: m=257, a=256, b=256 → x_o=65536, m_bl_o=9, valid at edge 34. Reducer connected downstream yields 1.
- Max width: m=0xFFFFFFFF, a=b=0xFFFFFFFE → x_o=0xFFFFFFFC00000004, m_bl_o=32, SCAN 1 cycle, MUL 32 cycles, valid at edge 34.
- Errors:
  - m=0 → edge 2: out_valid_o=1, err_o=1, x_o=0, m_bl_o=0.
  - m=17, a=17, b=3 → err_o=1, m_o=17.
  - m=1 → err_o=1.
- Backpressure and handshake:
  - Hold out_ready_i=0 for 10 cycles after valid → x_o/m_bl_o/err_o stable.
  - in_ready_o=0 throughout the request.
  - A second in_valid_i pulsed mid-MUL is ignored.
  - After the handshake, in_ready_o=1 on the next cycle.
- Reset mid-operation: assert rst_i asynchronously (between edges) during MUL of m=127 → outputs immediately 0, in_ready_o=1, no out_valid_o. A fresh request afterwards completes with correct x_o.

Source files
------------

// File: rtl/shiftadd_operand_feeder.sv
// ---------------------------------------------------------------------------
// shiftadd_operand_feeder
//
// Producer-side front end for the shift-add folding reducer. Accepts an
// operand pair (a, b) and modulus m over a valid/ready handshake, range
// checks them, finds the bit-length of m with an MSB-down scan, forms the
// full product a*b with an LSB-first shift-add multiplier, and presents
// {x, m, m_bl} on a registered valid/ready output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   request valid
//   in_ready_o   feeder can accept (only while idle)
//   a_i, b_i     operands, must be < m
//   m_i          modulus, must be >= 2
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   x_o          product a*b (zero on error)
//   m_o          zero-extended modulus
//   m_bl_o       bit-length of m (zero on error)
//   err_o        range check failed (qualified by out_valid_o)
// ---------------------------------------------------------------------------
module shiftadd_operand_feeder #(
  parameter int DATA_LENGTH   = 64,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [OPERAND_WIDTH-1:0] a_i,
  input  logic [OPERAND_WIDTH-1:0] b_i,
  input  logic [OPERAND_WIDTH-1:0] m_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_LENGTH-1:0]   x_o,
  output logic [DATA_LENGTH-1:0]   m_o,
  output logic [DATA_LENGTH-1:0]   m_bl_o,
  output logic                     err_o
);

  localparam int IDX_W = $clog2(OPERAND_WIDTH);
  localparam int BL_W  = IDX_W + 1;
  localparam int EXT_W = DATA_LENGTH - OPERAND_WIDTH;

  localparam logic [OPERAND_WIDTH-1:0] M_MIN    = OPERAND_WIDTH'(2);
  localparam logic [IDX_W-1:0]         IDX_TOP  = IDX_W'(OPERAND_WIDTH - 1);
  localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
  localparam logic [BL_W-1:0]          BL_ONE   = BL_W'(1);
  localparam logic [DATA_LENGTH-1:0]   DATA_ZERO = DATA_LENGTH'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SCAN  = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q,     state_d;
  logic [OPERAND_WIDTH-1:0] a_q,         a_d;
  logic [OPERAND_WIDTH-1:0] b_q,         b_d;
  logic [OPERAND_WIDTH-1:0] m_q,         m_d;
  logic [IDX_W-1:0]         idx_q,       idx_d;
  logic [BL_W-1:0]          bl_q,        bl_d;
  logic [BL_W-1:0]          cnt_q,       cnt_d;
  logic [DATA_LENGTH-1:0]   acc_q,       acc_d;
  logic [DATA_LENGTH-1:0]   mcand_q,     mcand_d;
  logic [OPERAND_WIDTH-1:0] bsh_q,       bsh_d;
  logic                     in_ready_q,  in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_LENGTH-1:0]   x_q,         x_d;
  logic [DATA_LENGTH-1:0]   m_out_q,     m_out_d;
  logic [DATA_LENGTH-1:0]   m_bl_q,      m_bl_d;
  logic                     err_q,       err_d;

  logic [DATA_LENGTH-1:0]   sum_s;
  logic [BL_W-1:0]          bl_found_s;

  // Partial-product step and bit-length candidate shared by MUL/SCAN.
  always_comb begin
    sum_s      = bsh_q[0] ? (acc_q + mcand_q) : acc_q;
    bl_found_s = {1'b0, idx_q} + BL_ONE;
  end

  // Next-state and next-output logic for the feeder FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    idx_d       = idx_q;
    bl_d        = bl_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    bsh_d       = bsh_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    m_out_d     = m_out_q;
    m_bl_d      = m_bl_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          a_d        = a_i;
          b_d        = b_i;
          m_d        = m_i;
          in_ready_d = 1'b0;
          state_d    = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        if ((m_q < M_MIN) || (a_q >= m_q) || (b_q >= m_q)) begin
          x_d     = DATA_ZERO;
          m_out_d = {{EXT_W{1'b0}}, m_q};
          m_bl_d  = DATA_ZERO;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = IDX_TOP;
          state_d = S_SCAN;
        end
      end

      // m >= 2 guarantees a set bit, so the scan always ends before idx wraps.
      S_SCAN: begin
        if (m_q[idx_q]) begin
          bl_d    = bl_found_s;
          cnt_d   = bl_found_s;
          acc_d   = DATA_ZERO;
          mcand_d = {{EXT_W{1'b0}}, a_q};
          bsh_d   = b_q;
          state_d = S_MUL;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end

      // b < m, so every bit of b at or above m_bl is zero: m_bl steps suffice.
      S_MUL: begin
        acc_d   = sum_s;
        mcand_d = mcand_q << 1;
        bsh_d   = bsh_q >> 1;
        cnt_d   = cnt_q - BL_ONE;
        if (cnt_q == BL_ONE) begin
          x_d         = sum_s;
          m_out_d     = {{EXT_W{1'b0}}, m_q};
          m_bl_d      = {{(DATA_LENGTH-BL_W){1'b0}}, bl_q};
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end

      // The error path arrives here with out_valid low; it is raised one
      // cycle later so an error response appears two edges after acceptance.
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      idx_q       <= '0;
      bl_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      bsh_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      m_out_q     <= '0;
      m_bl_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      idx_q       <= idx_d;
      bl_q        <= bl_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      bsh_q       <= bsh_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      m_out_q     <= m_out_d;
      m_bl_q      <= m_bl_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign x_o         = x_q;
  assign m_o         = m_out_q;
  assign m_bl_o      = m_bl_q;
  assign err_o       = err_q;

endmodule
